pci_par_chk: RTL and testbench

PCI_PAR_CHK -- requirements
Module: pci_par_chk

---
 rtl/pci_pkg.sv | 40 ++++
 rtl/pci_par_err_cnt.sv | 32 +++
 rtl/pci_par_chk.sv | 112 +++++++++++
 tb/tb_pci_par_chk.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// ============================================================================
// Module   : pci_pkg
// Brief    : Shared PCI types and widths for the parity checker slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pci_pkg;

    localparam int C_AD_WIDTH  = 32;
    localparam int C_CBE_WIDTH = 4;
    localparam int C_CNT_WIDTH = 8;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    typedef enum logic [0:0] {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_t;

    typedef struct packed {
        logic   vld;
        phase_t kind;
        logic   exp_par;
    } chk_t;

    // PCI uses even parity across AD, C/BE# and PAR together.
    function automatic logic calc_par(
        input logic [C_AD_WIDTH-1:0]  ad,
        input logic [C_CBE_WIDTH-1:0] cbe_n
    );
        return ^{ad, cbe_n};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pci_par_err_cnt.sv
// ============================================================================
// Module   : pci_par_err_cnt
// Brief    : Saturating error counter with synchronous clear (clear+inc = 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_par_err_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= i_inc ? C_ONE : '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + C_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pci_par_chk.sv
// ============================================================================
// Module   : pci_par_chk
// Brief    : PCI address/data parity checker driving PERR#/SERR# at N+2.
//            Optional error counter enabled by PAR_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_par_chk
    import pci_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C_AD_WIDTH-1:0]  ad,
    input  logic [C_CBE_WIDTH-1:0] cbe_n,
    input  logic                   par,
    input  logic                   frame_n,
    input  logic                   irdy_n,
    input  logic                   trdy_n,
    input  logic                   perr_en,
    input  logic                   serr_en,
    input  logic                   stat_clr,
    output logic                   perr_n,
    output logic                   serr_n,
    output logic                   det_par_err
`ifdef PAR_ERR_CNT_EN
    ,
    output logic [C_CNT_WIDTH-1:0] err_cnt
`endif
);

    bus_state_t r_state;
    bus_state_t w_state_nxt;
    logic       w_addr_ph;
    logic       w_data_ph;
    chk_t       r_chk;
    logic       w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_ph   = 1'b0;
        w_data_ph   = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (!frame_n) begin
                    w_state_nxt = BUS_BUSY;
                    w_addr_ph   = 1'b1;
                end
            end
            BUS_BUSY: begin
                w_data_ph = !irdy_n && !trdy_n;
                if (frame_n && irdy_n) begin
                    w_state_nxt = BUS_IDLE;
                end
            end
            default: w_state_nxt = BUS_IDLE;
        endcase
    end

    // Stage 1: capture expected parity for the phase; PAR arrives next clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= '{vld: 1'b0, kind: PH_ADDR, exp_par: 1'b0};
        end else begin
            r_chk.vld     <= w_addr_ph || w_data_ph;
            r_chk.kind    <= w_data_ph ? PH_DATA : PH_ADDR;
            r_chk.exp_par <= calc_par(ad, cbe_n);
        end
    end

    assign w_err = r_chk.vld && (par != r_chk.exp_par);

    // Stage 2: compare and register the strobes; enables taken at compare time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_n      <= 1'b1;
            serr_n      <= 1'b1;
            det_par_err <= 1'b0;
        end else begin
            perr_n <= !(w_err && (r_chk.kind == PH_DATA) && perr_en);
            serr_n <= !(w_err && (r_chk.kind == PH_ADDR) && perr_en && serr_en);
            if (w_err) begin
                det_par_err <= 1'b1;
            end else if (stat_clr) begin
                det_par_err <= 1'b0;
            end
        end
    end

`ifdef PAR_ERR_CNT_EN
    pci_par_err_cnt #(
        .WIDTH (C_CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err),
        .i_clr (stat_clr),
        .o_cnt (err_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pci_par_chk.sv
// ============================================================================
// Module   : tb_pci_par_chk
// Brief    : Directed table-driven bench for pci_par_chk (counter checks
//            only when PAR_ERR_CNT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pci_par_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ad;
    logic [3:0]  cbe_n;
    logic        par;
    logic        frame_n, irdy_n, trdy_n;
    logic        perr_en, serr_en, stat_clr;
    logic        perr_n, serr_n, det_par_err;
`ifdef PAR_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pci_par_chk dut (
        .clk         (clk),
        .rst         (rst),
        .ad          (ad),
        .cbe_n       (cbe_n),
        .par         (par),
        .frame_n     (frame_n),
        .irdy_n      (irdy_n),
        .trdy_n      (trdy_n),
        .perr_en     (perr_en),
        .serr_en     (serr_en),
        .stat_clr    (stat_clr),
        .perr_n      (perr_n),
        .serr_n      (serr_n),
        .det_par_err (det_par_err)
`ifdef PAR_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic [31:0] ad;
        logic [3:0]  cbe_n;
        logic        par;
        logic        perr_en;
        logic        serr_en;
        logic        exp_perr_n;
        logic        exp_serr_n;
        logic        exp_det;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        trdy_n  = 1'b1;
    endtask

    // Address phase for a data transfer: ad=0, cbe_n=0111 -> good PAR is 1.
    task automatic addr_phase();
        frame_n = 1'b0; irdy_n = 1'b1; trdy_n = 1'b1;
        ad = 32'h0; cbe_n = 4'b0111; par = 1'b0;
        step();
    endtask

    initial begin
        int low_cnt;
        //             data ad            cbe      par pe se  perr serr det
        vecs[0] = '{1'b0, 32'h00000001, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'h00000001, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h00000001, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 32'h00000001, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'h80000000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 32'h12345678, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 32'h12345678, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; ad = '0; cbe_n = '0; par = 1'b0;
        perr_en = 1'b1; serr_en = 1'b1; stat_clr = 1'b0;
        bus_idle();
        step(); step();
        rst = 1'b0;
        step();
        chk("reset perr_n", perr_n, 1);
        chk("reset serr_n", serr_n, 1);
        chk("reset det", det_par_err, 0);
`ifdef PAR_ERR_CNT_EN
        chk("reset err_cnt", err_cnt, 0);
`endif

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_data) begin
                addr_phase();
                par = 1'b1;
                frame_n = 1'b1; irdy_n = 1'b0; trdy_n = 1'b0;
            end else begin
                frame_n = 1'b0; irdy_n = 1'b1; trdy_n = 1'b1;
                par = 1'b0;
            end
            ad = vecs[i].ad; cbe_n = vecs[i].cbe_n;
            step();
            bus_idle();
            par = vecs[i].par; perr_en = vecs[i].perr_en; serr_en = vecs[i].serr_en;
            ad = 32'hA5A5_0F0F; cbe_n = 4'b1010;
            step();
            chk($sformatf("v%0d perr_n", i), perr_n, vecs[i].exp_perr_n);
            chk($sformatf("v%0d serr_n", i), serr_n, vecs[i].exp_serr_n);
            chk($sformatf("v%0d det", i), det_par_err, vecs[i].exp_det);
`ifdef PAR_ERR_CNT_EN
            chk($sformatf("v%0d err_cnt", i), err_cnt, {7'd0, vecs[i].exp_det});
`endif
            par = ~vecs[i].par;
            step();
            chk($sformatf("v%0d perr_n pulse end", i), perr_n, 1);
            chk($sformatf("v%0d serr_n pulse end", i), serr_n, 1);
            perr_en = 1'b1; serr_en = 1'b1;
            stat_clr = 1'b1;
            step();
            stat_clr = 1'b0;
            chk($sformatf("v%0d det cleared", i), det_par_err, 0);
        end

        // Three back-to-back data phases, PAR 0,1,0 (middle one bad).
        addr_phase();
        frame_n = 1'b0; irdy_n = 1'b0; trdy_n = 1'b0;
        ad = 32'hFFFFFFFF; cbe_n = 4'b0000; par = 1'b1;
        step();
        chk("b2b addr ok", perr_n & serr_n, 1);
        par = 1'b0;
        step();
        chk("b2b d0 perr_n", perr_n, 1);
        frame_n = 1'b1; par = 1'b1;
        step();
        chk("b2b d1 perr_n", perr_n, 0);
        bus_idle(); par = 1'b0;
        step();
        chk("b2b d2 perr_n", perr_n, 1);
        chk("b2b det", det_par_err, 1);
`ifdef PAR_ERR_CNT_EN
        chk("b2b err_cnt", err_cnt, 1);
`endif
        stat_clr = 1'b1; step(); stat_clr = 1'b0;

        // Error and stat_clr on the same compare edge: set wins.
        addr_phase();
        frame_n = 1'b1; irdy_n = 1'b0; trdy_n = 1'b0;
        ad = 32'hFFFFFFFF; cbe_n = 4'b0000; par = 1'b1;
        step();
        bus_idle(); par = 1'b1; stat_clr = 1'b1;
        step();
        chk("set+clr det", det_par_err, 1);
        chk("set+clr perr_n", perr_n, 0);
`ifdef PAR_ERR_CNT_EN
        chk("set+clr err_cnt", err_cnt, 1);
`endif
        step();
        stat_clr = 1'b0;
        chk("clr alone det", det_par_err, 0);
`ifdef PAR_ERR_CNT_EN
        chk("clr alone err_cnt", err_cnt, 0);
`endif

        // Reset between a data phase and its PAR cycle drops the check.
        addr_phase();
        frame_n = 1'b1; irdy_n = 1'b0; trdy_n = 1'b0;
        ad = 32'hFFFFFFFF; cbe_n = 4'b0000; par = 1'b1;
        step();
        bus_idle(); par = 1'b1;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        chk("rst mid perr_n", perr_n, 1);
        chk("rst mid det", det_par_err, 0);
        step();
        chk("rst mid perr_n +1", perr_n, 1);

        // 300 consecutive bad data phases: one PERR# pulse each, counter saturates.
        low_cnt = 0;
        addr_phase();
        for (int i = 0; i < 300; i++) begin
            frame_n = (i == 299); irdy_n = 1'b0; trdy_n = 1'b0;
            ad = 32'hFFFFFFFF; cbe_n = 4'b0000; par = 1'b1;
            step();
            if (perr_n == 1'b0) low_cnt++;
        end
        bus_idle(); par = 1'b1;
        step();
        if (perr_n == 1'b0) low_cnt++;
        par = 1'b0;
        step();
        if (perr_n == 1'b0) low_cnt++;
        chk("stream perr pulses", low_cnt, 300);
        chk("stream det", det_par_err, 1);
`ifdef PAR_ERR_CNT_EN
        chk("stream err_cnt sat", err_cnt, 8'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
